// File: rtl/axi_chan_slice.sv
// axi_chan_slice: register slice for NUM_CH independent valid/ready channels.
// Each channel is built in one of four buffering modes, selected by MODE[2*i +: 2]:
//   0 bypass, 1 forward register, 2 two-entry skid, 3 circular FIFO of 2**LOG_DEPTH.
// Optional build macro AXI_CHAN_SLICE_STATS_EN adds per-channel saturating stall
// counters (stall_cnt) and a synchronous clear input (stats_clr).
//
// Skid channel (mode 2) states:
//   state    | meaning
//   ST_EMPTY | no beat held, m_valid low
//   ST_ONE   | one beat in main register
//   ST_TWO   | main and skid registers both hold beats, s_ready low
module axi_chan_slice #(
  parameter int                  NUM_CH    = 5,
  parameter int                  WIDTH     = 577,
  parameter logic [2*NUM_CH-1:0] MODE      = {NUM_CH{2'd2}},
  parameter int                  LOG_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       s_valid,
  output logic [NUM_CH-1:0]       s_ready,
  input  logic [NUM_CH*WIDTH-1:0] s_data,
  output logic [NUM_CH-1:0]       m_valid,
  input  logic [NUM_CH-1:0]       m_ready,
  output logic [NUM_CH*WIDTH-1:0] m_data,
  output logic [NUM_CH*7-1:0]     occ
`ifdef AXI_CHAN_SLICE_STATS_EN
  ,
  input  logic                    stats_clr,
  output logic [NUM_CH*32-1:0]    stall_cnt
`endif
);

  if (LOG_DEPTH < 1 || LOG_DEPTH > 6) begin : g_bad_depth
    $error("axi_chan_slice: LOG_DEPTH must be within 1..6");
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [1:0] CH_MODE = MODE[2*gi +: 2];

    if (CH_MODE == 2'd0) begin : g_bypass
      // Pure wires; stays transparent even while rst_n is low.
      assign m_valid[gi]               = s_valid[gi];
      assign m_data[gi*WIDTH +: WIDTH] = s_data[gi*WIDTH +: WIDTH];
      assign s_ready[gi]               = m_ready[gi];
      assign occ[gi*7 +: 7]            = 7'd0;

    end else if (CH_MODE == 2'd1) begin : g_fwd
      logic             r_full;
      logic [WIDTH-1:0] r_data;
      logic             w_srdy;
      logic             w_push;

      // Ready looks through to m_ready so a full register can refill on the pop cycle.
      assign w_srdy = rst_n && (!r_full || m_ready[gi]);
      assign w_push = s_valid[gi] && w_srdy;

      // Single holding register: load on push, empty on pop without refill.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_full <= 1'b0;
          r_data <= '0;
        end else if (w_push) begin
          r_full <= 1'b1;
          r_data <= s_data[gi*WIDTH +: WIDTH];
        end else if (m_ready[gi]) begin
          r_full <= 1'b0;
        end
      end

      assign s_ready[gi]               = w_srdy;
      assign m_valid[gi]               = r_full;
      assign m_data[gi*WIDTH +: WIDTH] = r_data;
      assign occ[gi*7 +: 7]            = {6'd0, r_full};

    end else if (CH_MODE == 2'd2) begin : g_skid
      localparam logic [1:0] ST_EMPTY = 2'd0;
      localparam logic [1:0] ST_ONE   = 2'd1;
      localparam logic [1:0] ST_TWO   = 2'd2;

      logic [1:0]       r_state;
      logic [1:0]       w_nxt;
      logic             r_rdy;
      logic [WIDTH-1:0] r_main;
      logic [WIDTH-1:0] r_skid;
      logic             w_srdy;
      logic             w_mv;
      logic [6:0]       w_occ;
      logic             w_push;
      logic             w_pop;

      // r_rdy powers up high so ready appears as soon as rst_n releases.
      assign w_srdy = r_rdy && rst_n;
      assign w_push = s_valid[gi] && w_srdy;
      assign w_pop  = w_mv && m_ready[gi];

      // State register plus registered ready (skid register empty next cycle).
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= ST_EMPTY;
          r_rdy   <= 1'b1;
        end else begin
          r_state <= w_nxt;
          r_rdy   <= (w_nxt != ST_TWO);
        end
      end

      // Next-state decode from push/pop.
      always_comb begin
        w_nxt = r_state;
        case (r_state)
          ST_EMPTY: if (w_push) w_nxt = ST_ONE;
          ST_ONE: begin
            if (w_push && !w_pop)      w_nxt = ST_TWO;
            else if (!w_push && w_pop) w_nxt = ST_EMPTY;
          end
          ST_TWO:   if (w_pop) w_nxt = ST_ONE;
          default:  w_nxt = ST_EMPTY;
        endcase
      end

      // Outputs decoded from the state register only.
      always_comb begin
        w_mv  = 1'b0;
        w_occ = 7'd0;
        case (r_state)
          ST_ONE: begin
            w_mv  = 1'b1;
            w_occ = 7'd1;
          end
          ST_TWO: begin
            w_mv  = 1'b1;
            w_occ = 7'd2;
          end
          default: begin
            w_mv  = 1'b0;
            w_occ = 7'd0;
          end
        endcase
      end

      // Datapath: main always holds the oldest beat; skid catches the overflow beat.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_main <= '0;
          r_skid <= '0;
        end else begin
          case (r_state)
            ST_EMPTY: if (w_push) r_main <= s_data[gi*WIDTH +: WIDTH];
            ST_ONE: begin
              if (w_push && w_pop)       r_main <= s_data[gi*WIDTH +: WIDTH];
              else if (w_push && !w_pop) r_skid <= s_data[gi*WIDTH +: WIDTH];
            end
            ST_TWO:   if (w_pop) r_main <= r_skid;
            default: begin
              r_main <= r_main;
            end
          endcase
        end
      end

      assign s_ready[gi]               = w_srdy;
      assign m_valid[gi]               = w_mv;
      assign m_data[gi*WIDTH +: WIDTH] = r_main;
      assign occ[gi*7 +: 7]            = w_occ;

    end else begin : g_fifo
      localparam int D = 1 << LOG_DEPTH;

      logic [WIDTH-1:0] r_mem [D];
      logic [LOG_DEPTH:0] r_wptr;
      logic [LOG_DEPTH:0] r_rptr;
      logic [LOG_DEPTH:0] w_cnt;
      logic               w_full;
      logic               w_empty;
      logic               w_srdy;
      logic               w_push;
      logic               w_pop;

      // Pointers carry one wrap bit: full when only the wrap bits differ.
      assign w_full  = (r_wptr == {~r_rptr[LOG_DEPTH], r_rptr[LOG_DEPTH-1:0]});
      assign w_empty = (r_wptr == r_rptr);
      assign w_srdy  = rst_n && !w_full;
      assign w_push  = s_valid[gi] && w_srdy;
      assign w_pop   = !w_empty && m_ready[gi];
      assign w_cnt   = r_wptr - r_rptr;

      // Pointer advance on push/pop.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_wptr <= '0;
          r_rptr <= '0;
        end else begin
          if (w_push) r_wptr <= r_wptr + 1'b1;
          if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
      end

      // Storage array; contents are don't-care until the pointer marks them valid.
      always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[LOG_DEPTH-1:0]] <= s_data[gi*WIDTH +: WIDTH];
      end

      assign s_ready[gi]               = w_srdy;
      assign m_valid[gi]               = !w_empty;
      assign m_data[gi*WIDTH +: WIDTH] = w_empty ? '0 : r_mem[r_rptr[LOG_DEPTH-1:0]];
      assign occ[gi*7 +: 7]            = 7'(w_cnt);
    end

`ifdef AXI_CHAN_SLICE_STATS_EN
    logic [31:0] r_stall;

    // Saturating count of cycles where the downstream holds off a valid beat.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_stall <= '0;
      end else if (stats_clr) begin
        r_stall <= '0;
      end else if (m_valid[gi] && !m_ready[gi] && (r_stall != 32'hFFFF_FFFF)) begin
        r_stall <= r_stall + 32'd1;
      end
    end

    assign stall_cnt[gi*32 +: 32] = r_stall;
`endif
  end

endmodule

// File: doc/axi_chan_slice.md
Name: axi_chan_slice

Overview:
- Generic, parametrised register slice for NUM_CH independent valid/ready channels, each carrying a WIDTH-bit payload.
- Each channel has its own selectable buffering mode: bypass, forward register, full skid, or FIFO.
- Sits between AXI masters/slaves and interconnect. AW/W/B/AR/R payloads are packed by a thin wrapper, so one block serves any AXI width set.
- Unlike the fixed-width FIFO slice, a push occurs only on valid&&ready, and the FIFO depth is a per-instance choice.

Parameters:
- NUM_CH, 5, number of independent channels.
- WIDTH, 577, payload bits per channel (all channels padded to this width).
- MODE, {NUM_CH{2'd2}}, 2 bits per channel: 0 bypass, 1 forward register, 2 full skid, 3 FIFO.
- LOG_DEPTH, 2, FIFO depth = 2**LOG_DEPTH for mode-3 channels; legal range 1..6.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  NUM_CH  upstream valid, one per channel
- s_ready  out  NUM_CH  upstream ready
- s_data  in  NUM_CH*WIDTH  upstream payload; channel i occupies bits [i*WIDTH +: WIDTH]
- m_valid  out  NUM_CH  downstream valid
- m_ready  in  NUM_CH  downstream ready
- m_data  out  NUM_CH*WIDTH  downstream payload, same packing as s_data
- occ  out  NUM_CH*7  per-channel entry count; 7 bits per channel, zero-extended

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset (rst_n low): all storage invalidated; m_valid=0, occ=0, m_data=0 in modes 1-3.
  - s_ready is forced 0 in modes 1-3 while rst_n is low, and is 1 in the first cycle after release.
  - Mode 0 passes signals through even during reset.
- Handshake, per channel and independent of other channels:
  - Push = s_valid&&s_ready; pop = m_valid&&m_ready.
  - Once m_valid rises, it and m_data hold stable until pop.
  - Order is preserved; no drop; no duplication.
- Mode 0: m_valid=s_valid, m_data=s_data, s_ready=m_ready. Latency 0; occ=0.
- Mode 1, single register:
  - s_ready = !full || m_ready (combinational from m_ready).
  - Latency 1; full throughput.
  - occ is 0 or 1.
- Mode 2, two-entry skid (main + skid reg):
  - s_ready is registered: s_ready = skid empty.
  - States: EMPTY -> (push) ONE; ONE -> (push, no pop) TWO; ONE -> (push&&pop) ONE; ONE -> (pop only) EMPTY; TWO -> (pop) ONE.
  - On TWO->ONE, the skid entry moves to main.
  - No combinational path in either direction; latency 1; sustained 1 beat/cycle.
- Mode 3, circular FIFO of depth D=2**LOG_DEPTH:
  - Read/write pointers are LOG_DEPTH+1 bits (wrap bit).
  - Full = pointers equal except MSB; empty = pointers equal.
  - s_ready=!full; m_valid=!empty. No fall-through, so latency is 1.
  - Simultaneous push and pop: occ unchanged. When full, push cannot occur because s_ready is low.
  - m_data is registered from the head entry.
  - occ = write pointer minus read pointer (modulo 2**(LOG_DEPTH+1)), range 0..D.
- Reset mid-transfer discards all buffered beats; upstream must reissue.
- MODE codes outside 0..3 and LOG_DEPTH outside 1..6 are elaboration errors.

Optional Feature:
- Macro AXI_CHAN_SLICE_STATS_EN.
- When defined:
  - Adds output stall_cnt, NUM_CH*32 bits.
  - Per channel, a saturating counter increments every cycle with m_valid&&!m_ready. It holds at 32'hFFFF_FFFF.
  - Adds input stats_clr, 1 bit; it zeroes all counters synchronously. stats_clr wins over a same-cycle increment.
  - Counters reset to 0 on rst_n low.
- When not defined: neither port exists, and there are no counters or logic.

Test Plan:
- Mode 2, WIDTH=8, m_ready=1, push 0x01..0x10 back-to-back -> m_data 0x01..0x10 one cycle later, one beat per cycle, s_ready never low.
- Mode 2, push 0xA1,0xA2 with m_ready=0 -> occ=2 and s_ready=0 next cycle. Then m_ready=1 -> 0xA1 then 0xA2 on consecutive cycles, and s_ready=1 after the first pop.
- Mode 3, LOG_DEPTH=2, m_ready=0, push 6 beats 0x10..0x15 -> only 0x10..0x13 accepted; s_ready=0 at occ=4. Drain -> exactly 0x10..0x13 in order.
- Mode 3, full, simultaneous push 0x20 and pop -> push refused (s_ready=0); occ 4->3; next push accepted, occ back to 4. Wrap is exercised over 20 beats with no reordering.
- NUM_CH=3, MODE={3,1,0}: drive random m_ready per channel -> each channel matches its scoreboard; the mode-0 channel shows zero-latency passthrough.
- Assert rst_n low while mode-3 occ=3 -> m_valid=0 and occ=0 immediately (asynchronously). After release, s_ready=1 and the first pushed beat 0x55 emerges first.
